serial_frame_demux: RTL and testbench

Parametrised serial-to-parallel frame demultiplexer. It receives a framed serial stream on one line and decodes an address and a length header. It routes the payload bits to one of 2**ADDR_W channels, both as a bit stream and as assembled DATA_W-bit words. It checks the stop bit and resynchronises after framing errors. It sits between the serial line input and the per-channel consumers.

---
 rtl/serial_demux_pkg.sv | 18 +
 rtl/serial_word_packer.sv | 51 +++++
 rtl/serial_frame_demux.sv | 121 ++++++++++++
 tb/tb_serial_frame_demux.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_demux_pkg.sv
// Shared state encoding and header geometry for the serial frame demultiplexer.
// Stateless package; no latency or flow control of its own.
package serial_demux_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_HDR  = 3'd1;
  localparam state_t ST_PAY  = 3'd2;
  localparam state_t ST_STOP = 3'd3;
  localparam state_t ST_ERR  = 3'd4;

  // Number of serial header bits that follow the start bit.
  function automatic int hdr_len(input int addr_w, input int len_w);
    return addr_w + len_w;
  endfunction

endpackage

// File: rtl/serial_word_packer.sv
// Packs payload bits MSB-first into DATA_W words; a flush emits the partial word right-justified.
// Outputs registered one cycle after the shifted bit; no backpressure (DATA_W >= 2).
module serial_word_packer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift,
  input  logic              din,
  input  logic              flush,
  output logic [DATA_W-1:0] word_data,
  output logic              word_valid,
  output logic              word_last
);

  localparam int CW = $clog2(DATA_W);

  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] word_nxt;
  logic [CW-1:0]     cnt;
  logic              full;

  assign word_nxt = {word[DATA_W-2:0], din};
  assign full     = (cnt == CW'(DATA_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word       <= '0;
      cnt        <= '0;
      word_data  <= '0;
      word_valid <= 1'b0;
      word_last  <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      word_last  <= 1'b0;
      if (shift) begin
        if (full || flush) begin
          word_data  <= word_nxt;
          word_valid <= 1'b1;
          word_last  <= flush;
          word       <= '0;
          cnt        <= '0;
        end else begin
          word <= word_nxt;
          cnt  <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/serial_frame_demux.sv
// Decodes start/addr/len/payload/stop serial frames and steers payload bits and words to a channel.
// All outputs one cycle after the sampling edge; no backpressure, the line is never stalled.
module serial_frame_demux
  import serial_demux_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int LEN_W  = 6,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sIn,
  output logic                valid,
  output logic [2**ADDR_W-1:0] ch_sel,
  output logic                ch_bit,
  output logic [DATA_W-1:0]   word_data,
  output logic [ADDR_W-1:0]   word_ch,
  output logic                word_valid,
  output logic                word_last,
  output logic                frame_done,
  output logic                error,
  output logic                busy
);

  localparam int NCH     = 2**ADDR_W;
  localparam int HDR_LEN = hdr_len(ADDR_W, LEN_W);
  localparam int HCW     = $clog2(HDR_LEN);

  state_t             state;
  logic [HCW-1:0]     hdr_cnt;
  logic [HDR_LEN-1:0] hdr_sh;
  logic [HDR_LEN-1:0] hdr_nxt;
  logic [LEN_W-1:0]   pay_cnt;
  logic [ADDR_W-1:0]  addr;
  logic               hdr_done;
  logic               pay_take;
  logic               pay_last;

  // Address sits in the top bits once the whole header has been shifted in.
  assign hdr_nxt  = {hdr_sh[HDR_LEN-2:0], sIn};
  assign addr     = hdr_sh[HDR_LEN-1 -: ADDR_W];
  assign hdr_done = (state == ST_HDR) && (hdr_cnt == HCW'(HDR_LEN - 1));
  assign pay_take = (state == ST_PAY);
  assign pay_last = pay_take && (pay_cnt == LEN_W'(1));
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      hdr_cnt    <= '0;
      hdr_sh     <= '0;
      pay_cnt    <= '0;
      valid      <= 1'b0;
      ch_sel     <= '0;
      ch_bit     <= 1'b0;
      word_ch    <= '0;
      frame_done <= 1'b0;
      error      <= 1'b0;
    end else begin
      valid      <= pay_take;
      ch_bit     <= pay_take & sIn;
      ch_sel     <= pay_take ? (NCH'(1) << addr) : '0;
      frame_done <= (state == ST_STOP) && sIn;
      error      <= (state == ST_STOP) && !sIn;
      if (pay_take) begin
        word_ch <= addr;
      end

      case (state)
        ST_IDLE: begin
          if (!sIn) begin
            state   <= ST_HDR;
            hdr_cnt <= '0;
          end
        end
        ST_HDR: begin
          hdr_sh  <= hdr_nxt;
          hdr_cnt <= hdr_cnt + 1'b1;
          if (hdr_done) begin
            if (hdr_nxt[LEN_W-1:0] == '0) begin
              state <= ST_STOP;
            end else begin
              state   <= ST_PAY;
              pay_cnt <= hdr_nxt[LEN_W-1:0];
            end
          end
        end
        ST_PAY: begin
          pay_cnt <= pay_cnt - 1'b1;
          if (pay_last) begin
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          state <= sIn ? ST_IDLE : ST_ERR;
        end
        // The low that caused the error is consumed here, so it never looks like a start bit.
        ST_ERR: begin
          if (sIn) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  serial_word_packer #(
    .DATA_W(DATA_W)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .shift     (pay_take),
    .din       (sIn),
    .flush     (pay_last),
    .word_data (word_data),
    .word_valid(word_valid),
    .word_last (word_last)
  );

endmodule

// File: tb/tb_serial_frame_demux.sv
// Directed frame stimulus with a protocol-level timeline model and literal pins on the decoded stream.
module tb_serial_frame_demux;

  localparam int ADDR_W = 2;
  localparam int LEN_W  = 6;
  localparam int DATA_W = 8;
  localparam int NCH    = 4;
  localparam int H      = ADDR_W + LEN_W;
  localparam int MAXN   = 512;

  logic              clk = 1'b0;
  logic              rst;
  logic              sIn;
  logic              valid;
  logic [NCH-1:0]    ch_sel;
  logic              ch_bit;
  logic [DATA_W-1:0] word_data;
  logic [ADDR_W-1:0] word_ch;
  logic              word_valid;
  logic              word_last;
  logic              frame_done;
  logic              error;
  logic              busy;

  serial_frame_demux #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .sIn(sIn), .valid(valid), .ch_sel(ch_sel), .ch_bit(ch_bit),
    .word_data(word_data), .word_ch(word_ch), .word_valid(word_valid), .word_last(word_last),
    .frame_done(frame_done), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  // Line schedule: one entry per sampling edge.
  logic line   [MAXN];
  logic rst_at [MAXN];
  int   n_smp;
  int   cur;
  logic running = 1'b0;

  // Expected outputs just after each sampling edge.
  logic              e_valid [MAXN];
  logic              e_bit   [MAXN];
  logic [NCH-1:0]    e_sel   [MAXN];
  logic              e_wv    [MAXN];
  logic [DATA_W-1:0] e_wd    [MAXN];
  logic [ADDR_W-1:0] e_wch   [MAXN];
  logic              e_wl    [MAXN];
  logic              e_fd    [MAXN];
  logic              e_err   [MAXN];
  logic              e_busy  [MAXN];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s sample %0d: got %0h want %0h", name, cur, act, exp);
  endtask

  task automatic add_bit(input logic b, input logic r);
    line[n_smp]   = b;
    rst_at[n_smp] = r;
    n_smp++;
  endtask

  task automatic add_idle(input int k);
    for (int i = 0; i < k; i++) add_bit(1'b1, 1'b0);
  endtask

  // cut >= 0 replaces payload bit number 'cut' with a reset step and abandons the frame.
  task automatic add_frame(input int a, input int l, input logic [63:0] pay, input logic stop, input int cut);
    add_bit(1'b0, 1'b0);
    for (int i = ADDR_W - 1; i >= 0; i--) add_bit(a[i], 1'b0);
    for (int i = LEN_W - 1; i >= 0; i--) add_bit(l[i], 1'b0);
    for (int i = l - 1; i >= 0; i--) begin
      if (cut >= 0 && (l - 1 - i) == cut) begin
        add_bit(1'b1, 1'b1);
        return;
      end
      add_bit(pay[i], 1'b0);
    end
    add_bit(stop, 1'b0);
  endtask

  // Walks the line as a protocol reader would and marks what each sample must produce.
  task automatic build_model();
    int p, q, a, l, acc, k;
    logic ok;
    for (int i = 0; i < MAXN; i++) begin
      e_valid[i] = 0; e_bit[i] = 0; e_sel[i] = '0; e_wv[i] = 0; e_wd[i] = '0;
      e_wch[i] = '0; e_wl[i] = 0; e_fd[i] = 0; e_err[i] = 0; e_busy[i] = 0;
    end
    p = 0;
    while (p < n_smp) begin
      if (rst_at[p] || line[p]) begin
        p++;
        continue;
      end
      q = p; e_busy[q] = 1; ok = 1; a = 0; l = 0;
      for (int i = 0; i < H; i++) begin
        q++;
        if (q >= n_smp || rst_at[q]) begin ok = 0; break; end
        e_busy[q] = 1;
        if (i < ADDR_W) a = a * 2 + int'(line[q]);
        else            l = l * 2 + int'(line[q]);
      end
      if (!ok) begin p = q; continue; end
      acc = 0; k = 0;
      for (int i = 0; i < l; i++) begin
        q++;
        if (q >= n_smp || rst_at[q]) begin ok = 0; break; end
        e_busy[q] = 1; e_valid[q] = 1; e_bit[q] = line[q];
        e_sel[q] = NCH'(1) << a;
        acc = acc * 2 + int'(line[q]); k++;
        if (k == DATA_W || i == l - 1) begin
          e_wv[q] = 1; e_wd[q] = acc[DATA_W-1:0]; e_wch[q] = a[ADDR_W-1:0];
          e_wl[q] = (i == l - 1); acc = 0; k = 0;
        end
      end
      if (!ok) begin p = q; continue; end
      q++;
      if (q >= n_smp || rst_at[q]) begin p = q; continue; end
      if (line[q]) begin
        e_fd[q] = 1;
        p = q + 1;
      end else begin
        e_err[q] = 1; e_busy[q] = 1; q++;
        while (q < n_smp && !rst_at[q] && !line[q]) begin e_busy[q] = 1; q++; end
        p = (q < n_smp && rst_at[q]) ? q : q + 1;
      end
    end
  endtask

  // Driver: builds the schedule, then presents one line bit per cycle.
  initial begin
    rst = 1'b1; sIn = 1'b1; n_smp = 0; cur = 0;
    add_idle(3);
    add_frame(2, 8, 64'hA5, 1'b1, -1);
    add_idle(2);
    add_frame(3, 11, 64'b10110011101, 1'b1, -1);
    add_idle(2);
    add_frame(1, 0, 64'h0, 1'b1, -1);
    add_idle(2);
    add_frame(0, 5, 64'b10011, 1'b0, -1);
    for (int i = 0; i < 5; i++) add_bit(1'b0, 1'b0);
    add_idle(2);
    add_frame(2, 3, 64'b110, 1'b1, -1);
    add_idle(2);
    add_frame(1, 8, 64'hC3, 1'b1, 4);
    add_idle(2);
    add_frame(1, 8, 64'h3C, 1'b1, -1);
    add_idle(2);
    add_frame(0, 4, 64'h9, 1'b1, -1);
    add_frame(3, 4, 64'h6, 1'b1, -1);
    add_idle(3);
    build_model();

    repeat (3) @(negedge clk);
    rst = 1'b0;
    running = 1'b1;
    for (int n = 0; n < n_smp; n++) begin
      cur = n;
      sIn = line[n];
      rst = rst_at[n];
      @(negedge clk);
    end
    rst = 1'b0;
    sIn = 1'b1;
    running = 1'b0;
  end

  // Compare process: checks every cycle against the model, then pins the decoded stream.
  logic [4:0]  bits  [$];
  logic [10:0] words [$];
  int          runs  [$];
  int          fd_cnt = 0;
  int          err_cnt = 0;
  int          run_len = 0;

  initial begin : compare
    logic [10:0] lit_words [8];
    logic [7:0]  a5;
    int          n;
    logic        finished;
    lit_words = '{ {8'hA5, 2'd2, 1'b1}, {8'hB3, 2'd3, 1'b0}, {8'h05, 2'd3, 1'b1}, {8'h13, 2'd0, 1'b1},
                   {8'h06, 2'd2, 1'b1}, {8'h3C, 2'd1, 1'b1}, {8'h09, 2'd0, 1'b1}, {8'h06, 2'd3, 1'b1} };
    a5 = 8'hA5;
    finished = 1'b0;

    @(negedge clk); #1;
    chk("reset_state", {valid, ch_sel, ch_bit, word_data, word_ch, word_valid, word_last,
                        frame_done, error, busy}, 64'h0);
    wait (running);
    for (int cyc = 0; cyc < MAXN + 8; cyc++) begin
      @(posedge clk); #2;
      if (!running) begin finished = 1'b1; break; end
      n = cur;
      chk("valid", valid, e_valid[n]);
      chk("ch_sel", ch_sel, e_sel[n]);
      chk("ch_bit", ch_bit, e_bit[n]);
      chk("word_valid", word_valid, e_wv[n]);
      chk("word_last", word_last, e_wl[n]);
      if (e_wv[n]) begin
        chk("word_data", word_data, e_wd[n]);
        chk("word_ch", word_ch, e_wch[n]);
      end
      chk("frame_done", frame_done, e_fd[n]);
      chk("error", error, e_err[n]);
      chk("busy", busy, e_busy[n]);

      if (valid) bits.push_back({ch_sel, ch_bit});
      if (word_valid) words.push_back({word_data, word_ch, word_last});
      fd_cnt  += int'(frame_done);
      err_cnt += int'(error);
      if (busy) run_len++;
      else if (run_len > 0) begin runs.push_back(run_len); run_len = 0; end

      // Reset is raised half a cycle before its sample; outputs must already be clear.
      #4;
      if (rst) chk("rst_async", {valid, ch_sel, ch_bit, word_data, word_ch, word_valid,
                                 word_last, frame_done, error, busy}, 64'h0);
    end
    if (!finished) chk("timeout", 64'h1, 64'h0);

    chk("word_count", words.size(), 8);
    for (int i = 0; i < 8; i++)
      chk("lit_word", (i < words.size()) ? words[i] : 11'h7FF, lit_words[i]);
    for (int i = 0; i < 8; i++)
      chk("lit_bit_a5", (i < bits.size()) ? bits[i] : 5'h1F, {4'b0100, a5[7-i]});
    for (int i = 8; i < 19; i++)
      chk("lit_sel_ch3", (i < bits.size()) ? bits[i][4:1] : 4'hF, 4'b1000);
    chk("frame_done_count", fd_cnt, 7);
    chk("error_count", err_cnt, 1);
    // Empty frame: busy rises after the start sample and drops after the stop sample,
    // spanning the 1+2+6+1 sample edges as 9 busy cycles.
    chk("len0_busy_run", (runs.size() > 2) ? runs[2] : -1, 9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
